// File: rtl/avr_loader_pkg.sv
// Shared types and frame constants for the serial program-memory loader.
// The frame is: SYNC, LEN_LO, LEN_HI, LEN x {first byte, second byte}, CKSUM.
package avr_loader_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned WORD_W            = 16;
  localparam int unsigned LEN_W             = 16;
  localparam int unsigned ADDR_W_DEFAULT    = 9;
  localparam int unsigned MAX_WORDS_DEFAULT = 512;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'h55;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  // Program word as stored in ROM order; the fetch path swaps the bytes.
  typedef struct packed {
    logic [BYTE_W-1:0] first;
    logic [BYTE_W-1:0] second;
  } pm_word_t;

  // CPU is held for the whole frame, released only when idle or failed.
  function automatic logic state_stalls_cpu(input loader_state_e s);
    return !(s == IDLE || s == ERROR);
  endfunction

  // Byte intake pauses only while a word is written or the CPU is reset.
  function automatic logic state_takes_byte(input loader_state_e s);
    return !(s == WRITE || s == DONE);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program image byte-by-byte, writes it into program memory
// as 16-bit words, verifies an 8-bit additive checksum and pulses the CPU reset.
module prog_loader
  import avr_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned       MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_wdata,
  output logic              pm_we,
  output logic              cpu_stall,
  output logic              cpu_rst,
  output logic              load_err
);

  loader_state_e state_q, state_n;

  logic [BYTE_W-1:0] len_lo_q, len_lo_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [BYTE_W-1:0] first_q, first_n;
  logic [BYTE_W-1:0] sum_q, sum_n;
  logic [LEN_W-1:0]  idx_q, idx_n;

  logic [ADDR_W-1:0] pm_addr_n;
  pm_word_t          pm_wdata_n;
  logic              load_err_n;
  logic              accept_c;
  logic              is_sync_c;
  logic [LEN_W-1:0]  len_full_c;
  logic [LEN_W-1:0]  idx_inc_c;

  assign accept_c   = rx_valid & rx_ready;
  assign is_sync_c  = (rx_data == SYNC_BYTE);
  assign len_full_c = {rx_data, len_lo_q};
  assign idx_inc_c  = idx_q + LEN_W'(1);

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_n    = state_q;
    len_lo_n   = len_lo_q;
    len_n      = len_q;
    first_n    = first_q;
    sum_n      = sum_q;
    idx_n      = idx_q;
    pm_addr_n  = pm_addr;
    pm_wdata_n = pm_word_t'(pm_wdata);
    load_err_n = load_err;

    unique case (state_q)
      IDLE, ERROR: begin
        // Resync is only honoured between frames, never inside one.
        if (accept_c && is_sync_c) begin
          state_n    = LEN_LO;
          sum_n      = '0;
          idx_n      = '0;
          load_err_n = 1'b0;
        end
      end

      LEN_LO: begin
        if (accept_c) begin
          len_lo_n = rx_data;
          state_n  = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept_c) begin
          len_n = len_full_c;
          if (32'(len_full_c) > MAX_WORDS) begin
            state_n = ERROR;
          end else if (len_full_c == '0) begin
            state_n = CHECK;
          end else begin
            state_n = DATA_LO;
          end
        end
      end

      DATA_LO: begin
        if (accept_c) begin
          first_n = rx_data;
          sum_n   = sum_q + rx_data;
          state_n = DATA_HI;
        end
      end

      DATA_HI: begin
        if (accept_c) begin
          sum_n             = sum_q + rx_data;
          pm_wdata_n.first  = first_q;
          pm_wdata_n.second = rx_data;
          pm_addr_n         = ADDR_W'(idx_q);
          state_n           = WRITE;
        end
      end

      WRITE: begin
        idx_n   = idx_inc_c;
        state_n = (idx_inc_c == len_q) ? CHECK : DATA_LO;
      end

      CHECK: begin
        if (accept_c) begin
          state_n = (rx_data == sum_q) ? DONE : ERROR;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == ERROR) begin
      load_err_n = 1'b1;
    end
  end

  // State, datapath and output registers; reset wins over any accepted byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      first_q   <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      pm_we     <= 1'b0;
      cpu_stall <= 1'b0;
      cpu_rst   <= 1'b0;
      load_err  <= 1'b0;
      rx_ready  <= 1'b1;
    end else begin
      state_q   <= state_n;
      len_lo_q  <= len_lo_n;
      len_q     <= len_n;
      first_q   <= first_n;
      sum_q     <= sum_n;
      idx_q     <= idx_n;
      pm_addr   <= pm_addr_n;
      pm_wdata  <= WORD_W'(pm_wdata_n);
      pm_we     <= (state_n == WRITE);
      cpu_stall <= state_stalls_cpu(state_n);
      cpu_rst   <= (state_n == DONE);
      load_err  <= load_err_n;
      rx_ready  <= state_takes_byte(state_n);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected program-memory writes are queued
// as frames are sent and retired by a monitor watching pm_we.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [8:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        pm_we;
  logic        cpu_stall;
  logic        cpu_rst;
  logic        load_err;

  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rst_cnt = 0;
  int ready_low_cnt = 0;

  prog_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .pm_addr   (pm_addr),
    .pm_wdata  (pm_wdata),
    .pm_we     (pm_we),
    .cpu_stall (cpu_stall),
    .cpu_rst   (cpu_rst),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  // Retire expected writes and count strobes away from the active edge.
  always @(negedge CLK) begin
    wr_t e;
    if (pm_we === 1'b1) begin
      we_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", pm_addr, pm_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({pm_addr, pm_wdata} !== e) begin
          errors++;
          $display("FAIL write_content got addr=%h data=%h want addr=%h data=%h",
                   pm_addr, pm_wdata, e.addr, e.data);
        end
      end
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_during_write got %b want 0", rx_ready);
      end
    end
    if (cpu_rst === 1'b1) rst_cnt++;
    if (RST === 1'b0 && rx_ready === 1'b0 && cpu_rst !== 1'b1) ready_low_cnt++;
  end

  // Present a byte at a negedge and hold it until it has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL byte_timeout byte=%h ready=%b want 1", b, rx_ready);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // Send n random words from address 0, queueing their expected writes.
  task automatic load_words(input int n, output logic [7:0] sum);
    logic [7:0] a, b;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp_q.push_back({9'(i), a, b});
      sum = sum + a + b;
      send_byte(a);
      send_byte(b);
    end
  endtask

  task automatic test_reset;
    RST      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge CLK);
    checks++;
    if ({rx_ready, pm_we, cpu_stall, cpu_rst, load_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 10000",
               {rx_ready, pm_we, cpu_stall, cpu_rst, load_err});
    end
    checks++;
    if ({pm_addr, pm_wdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h data=%h want 0 0", pm_addr, pm_wdata);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_good_frame;
    int r0;
    logic [7:0] ck;
    r0 = rst_cnt;
    ck = 8'h0E + 8'h94 + 8'h0C + 8'h94;
    exp_q.push_back({9'd0, 16'h0E94});
    exp_q.push_back({9'd1, 16'h0C94});
    send_byte(8'h55);
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL good_stall got %b want 1", cpu_stall);
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h0E); send_byte(8'h94); send_byte(8'h0C); send_byte(8'h94);
    send_byte(ck);
    idle(3);
    checks++;
    if (rst_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL good_cpu_rst got %0d pulses want 1", rst_cnt - r0);
    end
    checks++;
    if ({load_err, cpu_stall} !== 2'b00) begin
      errors++;
      $display("FAIL good_flags got err=%b stall=%b want 0 0", load_err, cpu_stall);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL good_writes got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_bad_cksum;
    int r0;
    r0 = rst_cnt;
    exp_q.push_back({9'd0, 16'h0E94});
    exp_q.push_back({9'd1, 16'h0C94});
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h0E); send_byte(8'h94); send_byte(8'h0C); send_byte(8'h94);
    send_byte(8'h45);
    idle(3);
    checks++;
    if (rst_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL badck_cpu_rst got %0d pulses want 0", rst_cnt - r0);
    end
    checks++;
    if ({load_err, cpu_stall} !== 2'b10) begin
      errors++;
      $display("FAIL badck_flags got err=%b stall=%b want 1 0", load_err, cpu_stall);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL badck_writes got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_len_too_big;
    int w0, r0;
    w0 = we_cnt;
    r0 = rst_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02);
    idle(2);
    checks++;
    if ({load_err, cpu_stall, rx_ready} !== 3'b101) begin
      errors++;
      $display("FAIL toobig_flags got err=%b stall=%b ready=%b want 1 0 1",
               load_err, cpu_stall, rx_ready);
    end
    send_byte(8'h55);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL toobig_resync_err got %b want 0", load_err);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    checks++;
    if (we_cnt - w0 !== 0 || rst_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL toobig_result got writes=%0d pulses=%0d want 0 1",
               we_cnt - w0, rst_cnt - r0);
    end
  endtask

  task automatic test_garbage_prefix;
    int w0, r0;
    w0 = we_cnt;
    r0 = rst_cnt;
    send_byte(8'h12); send_byte(8'h34);
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL garbage_stall got %b want 0", cpu_stall);
    end
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    checks++;
    if (we_cnt - w0 !== 0 || rst_cnt - r0 !== 1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL garbage_result got writes=%0d pulses=%0d err=%b want 0 1 0",
               we_cnt - w0, rst_cnt - r0, load_err);
    end
  endtask

  task automatic test_back_to_back;
    int w0, r0, l0;
    logic [7:0] ck;
    w0 = we_cnt;
    r0 = rst_cnt;
    l0 = ready_low_cnt;
    send_byte(8'h55); send_byte(8'h03); send_byte(8'h00);
    load_words(3, ck);
    send_byte(ck);
    idle(3);
    checks++;
    if (we_cnt - w0 !== 3 || ready_low_cnt - l0 !== 3) begin
      errors++;
      $display("FAIL b2b_counts got writes=%0d ready_low=%0d want 3 3",
               we_cnt - w0, ready_low_cnt - l0);
    end
    checks++;
    if (rst_cnt - r0 !== 1 || load_err !== 1'b0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_result got pulses=%0d err=%b pending=%0d want 1 0 0",
               rst_cnt - r0, load_err, exp_q.size());
    end
  endtask

  task automatic test_stall_sync_in_data;
    int r0;
    logic [7:0] ck;
    r0 = rst_cnt;
    ck = 8'h55 + 8'h55;
    exp_q.push_back({9'd0, 16'h5555});
    send_byte(8'h55); idle(4);
    send_byte(8'h01); idle(4);
    send_byte(8'h00); idle(4);
    send_byte(8'h55); idle(6);
    checks++;
    if ({cpu_stall, rx_ready, pm_we} !== 3'b110) begin
      errors++;
      $display("FAIL stall_hold got stall=%b ready=%b we=%b want 1 1 0",
               cpu_stall, rx_ready, pm_we);
    end
    send_byte(8'h55); idle(4);
    send_byte(ck);
    idle(3);
    checks++;
    if (rst_cnt - r0 !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_result got pulses=%0d pending=%0d want 1 0",
               rst_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_rst_mid_frame;
    int r0;
    logic [7:0] ck;
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({cpu_stall, rx_ready, load_err} !== 3'b010) begin
      errors++;
      $display("FAIL midrst_state got stall=%b ready=%b err=%b want 0 1 0",
               cpu_stall, rx_ready, load_err);
    end
    RST = 1'b0;
    idle(1);
    r0 = rst_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h00);
    load_words(1, ck);
    send_byte(ck);
    idle(3);
    checks++;
    if (rst_cnt - r0 !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL midrst_reload got pulses=%0d pending=%0d want 1 0",
               rst_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_max_len;
    int w0, r0;
    logic [7:0] ck;
    w0 = we_cnt;
    r0 = rst_cnt;
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h02);
    load_words(512, ck);
    send_byte(ck);
    idle(3);
    checks++;
    if (we_cnt - w0 !== 512 || rst_cnt - r0 !== 1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL maxlen_result got writes=%0d pulses=%0d err=%b want 512 1 0",
               we_cnt - w0, rst_cnt - r0, load_err);
    end
  endtask

  initial begin
    RST      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge CLK);
    test_reset();
    test_good_frame();
    test_bad_cksum();
    test_len_too_big();
    test_garbage_prefix();
    test_back_to_back();
    test_stall_sync_in_data();
    test_rst_mid_frame();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
